perlin_scan_scheduler: RTL and testbench
========================================

Name: perlin_scan_scheduler

Overview:
Sequences perlin_noise_generator for raster display. Each cycle it drives the generator's x/y/t inputs from the VGA beam position and a per-frame animation time. It also carries beam position and blanking through a delay line matched to the generator pipeline, so noise comes out aligned to pixel coordinates. It sits between the VGA sync generator and the colour mapper, and owns the run/pause/single-step animation control.

Parameters:
LATENCY, 4, generator pipeline depth in cycles (valid range 1..8)
ZOOM_SHIFT, 0, left shift applied to hpos/vpos before driving the generator (0..3)
T_INIT, 20'h00000, gen_t value loaded on reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
hpos  in  10  beam x
vpos  in  10  beam y
display_on  in  1  beam in visible area
frame_start  in  1  one-cycle pulse once per frame, during vblank
run  in  1  level: animate continuously
step  in  1  one-cycle pulse: advance one frame while paused
speed  in  4  time increment control
noise_in  in  8  generator noise output
gen_x  out  10  to generator x
gen_y  out  10  to generator y
gen_t  out  20  to generator t
pix_valid  out  1  aligned display_on
pix_x  out  10  aligned hpos
pix_y  out  10  aligned vpos
pix_noise  out  8  aligned noise, 0 when pix_valid=0
state  out  2  0=PAUSED, 1=RUNNING, 2=STEPPING

Behaviour:
- Reset (async, immediate): all delay-line stages cleared. gen_x=gen_y=0, gen_t=T_INIT, pix_* all 0, state=PAUSED.
- Drive stage: gen_x <= (hpos<<ZOOM_SHIFT)[9:0]; gen_y <= (vpos<<ZOOM_SHIFT)[9:0]. Both are registered every cycle, independent of state.
- Alignment: inputs sampled at edge n. Generator sees them during cycle n+1. noise_in for them is valid during cycle n+1+LATENCY.
- Output stage: pix_* are registered at the end of cycle n+1+LATENCY, so they are visible in cycle n+LATENCY+2.
- Delay line: depth LATENCY+1, carrying {display_on, hpos, vpos}. The unshifted hpos/vpos are carried.
- pix_noise <= delayed display_on ? noise_in : 0.
- Time increment: inc = {speed, 2'b00}. If speed=0, STEPPING uses inc=4; RUNNING uses inc=0 (frozen but running).
- gen_t arithmetic: gen_t <= gen_t + inc, modulo 2^20 (wraps silently).
- gen_t changes only on a cycle with frame_start=1, and is stable for the whole visible frame.
- FSM, evaluated each cycle:
  - PAUSED:
    - run=1 -> RUNNING (takes priority over step).
    - else step=1 -> STEPPING.
    - gen_t never changes in PAUSED. A frame_start in the same cycle as the transition does not advance.
  - RUNNING:
    - run=0 -> PAUSED, with no advance, even if frame_start=1 in the same cycle.
    - else frame_start=1 -> advance.
    - step is ignored.
  - STEPPING:
    - run=1 -> RUNNING; a coincident frame_start advances once.
    - else frame_start=1 -> advance once, then -> PAUSED.
    - Further step pulses are ignored.
- Simultaneous step and frame_start in PAUSED: enter STEPPING only; the advance happens on the next frame_start.
- Reset mid-frame: pix_valid drops the same cycle. After release, the first valid pixel appears LATENCY+2 cycles after display_on is seen.

Test Plan:
1. Assert rst mid-stream with pix_valid=1 -> same cycle: pix_valid=0, pix_noise=0, gen_t=T_INIT, state=0. All outputs hold through release until new input propagates.
2. Latency check, LATENCY=4, noise stub returns gen_x[7:0] delayed 4 cycles:
   - Stimulus: hpos=100, vpos=50, display_on=1 at edge 0, then display_on=0.
   - Required: cycle 6 shows pix_valid=1, pix_x=100, pix_y=50, pix_noise=100; cycle 7 shows pix_valid=0, pix_noise=0.
3. Zoom and run, ZOOM_SHIFT=2, hpos=300:
   - gen_x = 1200 mod 1024 = 176.
   - run=1, speed=3, three frame_start pulses -> gen_t=36, state=1.
4. Wrap: T_INIT=20'hFFFF8, run=1, speed=3, one frame_start -> gen_t=20'h00004.
5. Single step: paused, speed=0, step pulse, then two frame_start pulses -> gen_t=4 after the first, still 4 after the second; state goes 0→2→0.
6. Run dropped coincident with frame_start, gen_t=8, speed=1 -> gen_t stays 8, state=0. Also: step together with frame_start in PAUSED -> no advance that frame.

Source files
------------

// File: rtl/perlin_scan_scheduler.sv
// Perlin scan scheduler.
// Drives the noise generator's x/y/t inputs from the VGA beam and the animation
// clock. Beam position and blanking are delayed to line up with the generator's
// noise output. Also runs the PAUSED / RUNNING / STEPPING animation control.
module perlin_scan_scheduler #(
  parameter int          LATENCY    = 4,
  parameter int          ZOOM_SHIFT = 0,
  parameter logic [19:0] T_INIT     = 20'h00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  input  logic        frame_start,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  speed,
  input  logic [7:0]  noise_in,
  output logic [9:0]  gen_x,
  output logic [9:0]  gen_y,
  output logic [19:0] gen_t,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_noise,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        adv;
  logic [19:0] inc;

  // Delay line. Stage 0 holds the beam sampled alongside gen_x/gen_y.
  // Stage LATENCY lines up with noise_in for that pixel.
  logic       vld_p  [0:LATENCY];
  logic [9:0] hpos_p [0:LATENCY];
  logic [9:0] vpos_p [0:LATENCY];

  // Zoomed coordinate. The bits shifted past bit 9 are dropped, so the
  // pattern tiles instead of saturating.
  function automatic logic [9:0] zoom(input logic [9:0] v);
    logic [12:0] wide;
    wide = {3'b000, v} << ZOOM_SHIFT;
    return wide[9:0];
  endfunction

  // Per-frame time increment while running. speed=0 freezes the animation.
  function automatic logic [19:0] run_inc(input logic [3:0] s);
    return {14'd0, s, 2'b00};
  endfunction

  // Per-frame time increment for a single step. A step must always move
  // time, so speed=0 is promoted to the smallest non-zero increment.
  function automatic logic [19:0] step_inc(input logic [3:0] s);
    return (s == 4'd0) ? 20'd4 : {14'd0, s, 2'b00};
  endfunction

  // Drive stage: register the generator coordinates every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_x <= '0;
      gen_y <= '0;
    end else begin
      gen_x <= zoom(hpos);
      gen_y <= zoom(vpos);
    end
  end

  // Delay line: carry the raw beam position and blanking alongside the
  // generator pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        hpos_p[i] <= '0;
        vpos_p[i] <= '0;
      end
    end else begin
      vld_p[0]  <= display_on;
      hpos_p[0] <= hpos;
      vpos_p[0] <= vpos;
      for (int i = 1; i <= LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        hpos_p[i] <= hpos_p[i-1];
        vpos_p[i] <= vpos_p[i-1];
      end
    end
  end

  // Output stage: pair the delayed beam with the generator noise. Noise is
  // blanked outside the visible area.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_noise <= '0;
    end else begin
      pix_valid <= vld_p[LATENCY];
      pix_x     <= hpos_p[LATENCY];
      pix_y     <= vpos_p[LATENCY];
      pix_noise <= vld_p[LATENCY] ? noise_in : 8'd0;
    end
  end

  // Animation control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PAUSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and time-advance decision. Time can only move on a
  // frame_start, so gen_t is stable for the whole visible frame.
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    inc     = run_inc(speed);
    case (state_q)
      PAUSED: begin
        if (run) begin
          state_d = RUNNING;
        end else if (step) begin
          state_d = STEPPING;
        end
      end
      RUNNING: begin
        if (!run) begin
          state_d = PAUSED;
        end else if (frame_start) begin
          adv = 1'b1;
        end
      end
      STEPPING: begin
        inc = step_inc(speed);
        if (run) begin
          state_d = RUNNING;
          adv     = frame_start;
        end else if (frame_start) begin
          adv     = 1'b1;
          state_d = PAUSED;
        end
      end
      default: begin
        state_d = PAUSED;
      end
    endcase
  end

  // Animation time. It wraps modulo 2^20.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_t <= T_INIT;
    end else if (adv) begin
      gen_t <= gen_t + inc;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_perlin_scan_scheduler.sv
// Bench for perlin_scan_scheduler.
// Instance A: default parameters, with a noise stub that returns gen_x[7:0]
// four cycles late. Its pixel stream is checked by a scoreboard.
// Instance B: ZOOM_SHIFT=2 and T_INIT near the top of the range. It shares
// inputs with A and is used for the zoom and wrap checks.
module tb_perlin_scan_scheduler;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hpos, vpos;
  logic        display_on, frame_start, run, step;
  logic [3:0]  speed;

  logic [7:0]  noise_a;
  logic [9:0]  gen_x_a, gen_y_a, pix_x_a, pix_y_a;
  logic [19:0] gen_t_a;
  logic        pix_valid_a;
  logic [7:0]  pix_noise_a;
  logic [1:0]  state_a;

  logic [9:0]  gen_x_b, gen_y_b, pix_x_b, pix_y_b;
  logic [19:0] gen_t_b;
  logic        pix_valid_b;
  logic [7:0]  pix_noise_b;
  logic [1:0]  state_b;

  int checks   = 0;
  int failures = 0;
  logic [28:0] sbq[$];

  always #5 clk = ~clk;

  perlin_scan_scheduler #(.LATENCY(LAT), .ZOOM_SHIFT(0), .T_INIT(20'h00000)) dut_a (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .frame_start(frame_start), .run(run), .step(step), .speed(speed),
    .noise_in(noise_a), .gen_x(gen_x_a), .gen_y(gen_y_a), .gen_t(gen_t_a),
    .pix_valid(pix_valid_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .pix_noise(pix_noise_a), .state(state_a)
  );

  perlin_scan_scheduler #(.LATENCY(LAT), .ZOOM_SHIFT(2), .T_INIT(20'hFFFF8)) dut_b (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .frame_start(frame_start), .run(run), .step(step), .speed(speed),
    .noise_in(8'h00), .gen_x(gen_x_b), .gen_y(gen_y_b), .gen_t(gen_t_b),
    .pix_valid(pix_valid_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .pix_noise(pix_noise_b), .state(state_b)
  );

  // Generator stub: noise = gen_x[7:0], four cycles of pipeline.
  logic [7:0] ns [0:3];
  always_ff @(posedge clk) begin
    ns[0] <= gen_x_a[7:0];
    ns[1] <= ns[0];
    ns[2] <= ns[1];
    ns[3] <= ns[2];
  end
  assign noise_a = ns[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Fill the scoreboard with the blank entries that represent the cleared
  // delay line and output registers after reset.
  task automatic prefill();
    sbq.delete();
    repeat (LAT + 1) sbq.push_back(29'd0);
  endtask

  // Drive one beam cycle, push its expected pixel, then check the pixel due now.
  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic de,
                       input logic fs, input logic st);
    logic [28:0] e;
    hpos = h; vpos = v; display_on = de; frame_start = fs; step = st;
    sbq.push_back({de, h, v, (de ? h[7:0] : 8'd0)});
    @(negedge clk);
    e = sbq.pop_front();
    check("pix", {3'b000, pix_valid_a, pix_x_a, pix_y_a, pix_noise_a}, {3'b000, e});
  endtask

  task automatic idle();
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset asynchronously mid-cycle, check the immediate effect, hold
  // it across edges, then release it at a falling edge.
  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    check("rst_pix_valid", {31'd0, pix_valid_a}, 32'd0);
    check("rst_pix_noise", {24'd0, pix_noise_a}, 32'd0);
    check("rst_gen_t_a", {12'd0, gen_t_a}, 32'd0);
    check("rst_gen_t_b", {12'd0, gen_t_b}, 32'h000FFFF8);
    check("rst_state_a", {30'd0, state_a}, 32'd0);
    check("rst_gen_x_a", {22'd0, gen_x_a}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_pix", {3'b000, pix_valid_a, pix_x_a, pix_y_a, pix_noise_a}, 32'd0);
    display_on = 1'b0; frame_start = 1'b0; step = 1'b0;
    rst = 1'b0;
    prefill();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0; frame_start = 1'b0;
    run = 1'b0; step = 1'b0; speed = 4'd0;
    @(negedge clk);
    check("init_gen_x", {22'd0, gen_x_a}, 32'd0);
    check("init_gen_y", {22'd0, gen_y_a}, 32'd0);
    check("init_gen_t_a", {12'd0, gen_t_a}, 32'd0);
    check("init_gen_t_b", {12'd0, gen_t_b}, 32'h000FFFF8);
    check("init_pix", {3'b000, pix_valid_a, pix_x_a, pix_y_a, pix_noise_a}, 32'd0);
    check("init_state", {30'd0, state_a}, 32'd0);
    rst = 1'b0;
    prefill();

    // Single pixel latency, then a mixed visible/blank stream.
    drive(10'd100, 10'd50, 1'b1, 1'b0, 1'b0);
    repeat (LAT + 2) idle();
    for (int i = 0; i < 24; i++)
      drive(10'((i * 37) % 640), 10'(200 + i), (i % 3) != 0, 1'b0, 1'b0);
    drive(10'd1023, 10'd1023, 1'b1, 1'b0, 1'b0);
    drive(10'd255, 10'd0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a visible run while animating.
    run = 1'b1; speed = 4'd2;
    drive(10'd10, 10'd20, 1'b1, 1'b0, 1'b0);
    drive(10'd11, 10'd20, 1'b1, 1'b0, 1'b0);
    drive(10'd12, 10'd20, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(10'(13 + i), 10'd20, 1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, pix_valid_a}, 32'd1);
    check("pre_rst_gen_t", {12'd0, gen_t_a}, 32'd8);
    check("pre_rst_state", {30'd0, state_a}, 32'd1);
    run = 1'b0;
    reset_mid();
    drive(10'd5, 10'd6, 1'b1, 1'b0, 1'b0);
    repeat (LAT + 2) idle();

    // Zoom on instance B.
    drive(10'd300, 10'd260, 1'b1, 1'b0, 1'b0);
    check("zoom_gen_x_b", {22'd0, gen_x_b}, 32'd176);
    check("zoom_gen_y_b", {22'd0, gen_y_b}, 32'd16);
    check("zoom_gen_x_a", {22'd0, gen_x_a}, 32'd300);

    // Running with speed 3: three frames, B wraps past 2^20.
    run = 1'b1; speed = 4'd3;
    idle();
    check("run_state", {30'd0, state_a}, 32'd1);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    idle();
    check("run_t_a_1", {12'd0, gen_t_a}, 32'd12);
    check("wrap_t_b", {12'd0, gen_t_b}, 32'h00000004);
    for (int k = 0; k < 2; k++) begin
      drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
      idle();
    end
    check("run_t_a_3", {12'd0, gen_t_a}, 32'd36);
    check("run_t_b_3", {12'd0, gen_t_b}, 32'd28);
    check("run_state_b", {30'd0, state_b}, 32'd1);

    // Step is ignored while running; speed 0 freezes time.
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("run_step_ign", {30'd0, state_a}, 32'd1);
    speed = 4'd0;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    idle();
    check("run_frozen_t", {12'd0, gen_t_a}, 32'd36);

    // Dropping run on a frame_start: no advance, back to PAUSED.
    speed = 4'd1; run = 1'b0;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    idle();
    check("drop_t", {12'd0, gen_t_a}, 32'd36);
    check("drop_state", {30'd0, state_a}, 32'd0);

    // Single step with speed 0 advances by 4 exactly once.
    speed = 4'd0;
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("step_state", {30'd0, state_a}, 32'd2);
    idle();
    check("step_wait_t", {12'd0, gen_t_a}, 32'd36);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    check("step_t_1", {12'd0, gen_t_a}, 32'd40);
    check("step_back", {30'd0, state_a}, 32'd0);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    check("step_t_2", {12'd0, gen_t_a}, 32'd40);

    // step together with frame_start while paused: enter STEPPING only.
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    check("sf_state", {30'd0, state_a}, 32'd2);
    check("sf_t", {12'd0, gen_t_a}, 32'd40);
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("sf_step_ign", {30'd0, state_a}, 32'd2);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    check("sf_adv_t", {12'd0, gen_t_a}, 32'd44);
    check("sf_adv_state", {30'd0, state_a}, 32'd0);

    // From STEPPING, run with a coincident frame_start advances once.
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    run = 1'b1; speed = 4'd5;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    check("st_run_t", {12'd0, gen_t_a}, 32'd64);
    check("st_run_state", {30'd0, state_a}, 32'd1);

    // run beats step while paused.
    run = 1'b0;
    idle();
    check("pause_again", {30'd0, state_a}, 32'd0);
    run = 1'b1;
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("run_prio", {30'd0, state_a}, 32'd1);
    run = 1'b0;
    repeat (LAT + 2) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
